mc_cu: RTL and testbench
========================

Name: mc_cu

Overview:
- Multi-cycle control unit for the MIPS-subset CPU.
- Sequences one shared ALU and one unified instruction/data memory port through the IF, ID, EXE, MEM and WB states.
- Replaces the single-cycle combinational decoder when the datapath is rebuilt multi-cycle, with IR, PC and ALU-output registers.
- Drives every write strobe and mux select of that datapath.

Parameters:
- IF_S, 3'd0, fetch state encoding
- ID_S, 3'd1, decode state encoding
- EXE_S, 3'd2, execute state encoding
- MEM_S, 3'd3, memory state encoding
- WB_S, 3'd4, write-back state encoding

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational, same cycle
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  memory write enable
- wreg  out  1  register-file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU-output register
- regrt  out  1  destination select: 1 = rt, 0 = rd
- m2reg  out  1  write-back data select: 1 = memory, 0 = ALU-output register
- shift  out  1  ALU-A select: 1 = sa
- alusrca  out  1  ALU-A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU-B select: 00 = rt, 01 = 4, 10 = immediate, 11 = offset<<2
- aluc  out  4  ALU opcode
- pcsource  out  2  next PC select: 00 = ALU, 01 = ALU-output register (branch target), 10 = rs, 11 = jump target
- jal  out  1  forces destination register 31 and write data = PC
- sext  out  1  sign-extend the immediate
- state  out  3  current state, for debug

Behaviour:
- State register only; all control outputs are combinational from state, op, func and zero.
- resetn low: state becomes IF_S immediately. wpc, wir, wmem and wreg are forced to 0 while resetn is low. Reset mid-instruction abandons that instruction.
- Defaults in every state: all enables 0, every select 0, aluc = 0000.
- ALU opcodes (aluc):
  - add/addi/lw/sw/PC arithmetic = 0000
  - sub/beq/bne = 0100
  - and/andi = 0001
  - or/ori = 0101
  - xor/xori = 0010
  - lui = 0110
  - sll = 0011
  - srl = 0111
  - sra = 1111
- IF_S: wir=1, wpc=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00 → ID_S. The PC is incremented by 4 in this state.
- ID_S: alusrca=0, alusrcb=11, sext=1, aluc=add. This precomputes the branch target into the ALU-output register. Then, by instruction:
  - j: wpc=1, pcsource=11 → IF_S.
  - jal: additionally wreg=1, jal=1. Writes the already-incremented PC to r31 → IF_S.
  - jr (op 0, func 001000): wpc=1, pcsource=10 → IF_S.
  - Unsupported op/func: no strobes, → IF_S. Executes as a NOP.
  - All other supported instructions → EXE_S.
- EXE_S:
  - R-type: alusrca=1, alusrcb=00, aluc from func → WB_S. sll/srl/sra additionally set shift=1.
  - I-type arithmetic: alusrca=1, alusrcb=10 → WB_S.
    - addi: sext=1.
    - andi/ori/xori/lui: sext=0.
  - lw/sw: alusrca=1, alusrcb=10, sext=1, aluc=add → MEM_S.
  - beq/bne: alusrca=1, alusrcb=00, aluc=sub. Taken when beq & zero, or bne & !zero; taken sets wpc=1, pcsource=01. → IF_S in both cases.
- MEM_S: iord=1.
  - lw → WB_S.
  - sw: wmem=1 → IF_S.
- WB_S: wreg=1; regrt=1 for I-type and lw; m2reg=1 for lw → IF_S.
- Cycle counts:
  - j, jal, jr, unsupported: 2.
  - beq, bne: 3.
  - R-type, I-type arithmetic, sw: 4.
  - lw: 5.
- Illegal state encodings 5–7 → IF_S on the next edge, with no strobes.

Optional Feature:
- Macro: MC_MEM_WAIT_EN.
- Defined:
  - Adds input port mem_ready (1 bit), placed after zero.
  - In IF_S, wir/wpc are asserted and the state advances only when mem_ready=1; otherwise the state holds IF_S with all strobes 0.
  - In MEM_S, lw advances and sw asserts wmem only when mem_ready=1; otherwise MEM_S holds.
- Undefined: the port is absent and behaviour is identical to mem_ready tied to 1.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with op=100011 → state=0, wpc=wir=wmem=wreg=0. Release → IF_S strobes wir=1, wpc=1, alusrcb=01.
- add (op 0, func 100000): states 0→1→2→4→0. In EXE, aluc=0000, alusrca=1, alusrcb=00. In WB, wreg=1, regrt=0, m2reg=0.
- lw (op 100011) then sw (op 101011):
  - lw visits 0,1,2,3,4 (5 cycles); iord=1 in MEM; WB has m2reg=1, regrt=1.
  - sw visits 0,1,2,3 (4 cycles); wmem=1 only in MEM.
- beq (op 000100) with zero=1 → EXE has wpc=1, pcsource=01. With zero=0 → no wpc. bne (op 000101) is the inverse. Both return to state 0 after EXE.
- jal (op 000011) → ID has wpc=1, pcsource=11, wreg=1, jal=1; 2 cycles total. jr → ID has pcsource=10. Unsupported op 111111 → 2 cycles, no strobes.
- MC_MEM_WAIT_EN: mem_ready=0 for 3 cycles in IF_S → state stays 0 with wir=0; mem_ready=1 → wir=wpc=1, next state 1.
- MC_MEM_WAIT_EN: sw with mem_ready=0 for 2 cycles → state holds 3, wmem=0; mem_ready=1 → wmem=1, then state 0.
- Async reset mid-lw: resetn pulsed low in MEM_S → state=0 immediately, no wmem/wreg.

Source files
------------

// File: rtl/mc_cu_if.sv
// Control-unit <-> datapath bundle for the multi-cycle MIPS-subset CPU.
// Carries mem_ready only when MC_MEM_WAIT_EN is defined.
interface mc_cu_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
`ifdef MC_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic       iord;
    logic       regrt;
    logic       m2reg;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       jal;
    logic       sext;
    logic [2:0] state;

    modport master (
`ifdef MC_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  op, func, zero,
        output wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca,
        output alusrcb, aluc, pcsource, jal, sext, state
    );

    modport slave (
`ifdef MC_MEM_WAIT_EN
        output mem_ready,
`endif
        output op, func, zero,
        input  wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca,
        input  alusrcb, aluc, pcsource, jal, sext, state
    );
endinterface

// File: rtl/mc_cu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer driving all datapath strobes/selects.
// Optional MC_MEM_WAIT_EN adds a mem_ready stall in IF and MEM.
module mc_cu #(
    parameter logic [2:0] IF_S  = 3'd0,
    parameter logic [2:0] ID_S  = 3'd1,
    parameter logic [2:0] EXE_S = 3'd2,
    parameter logic [2:0] MEM_S = 3'd3,
    parameter logic [2:0] WB_S  = 3'd4
) (
    input  logic      clock,
    input  logic      resetn,
    mc_cu_if.master   bus
);
    typedef enum logic [2:0] {
        ST_IF  = IF_S,
        ST_ID  = ID_S,
        ST_EXE = EXE_S,
        ST_MEM = MEM_S,
        ST_WB  = WB_S
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101, F_XOR = 6'b100110, F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010, F_SRA = 6'b000011, F_JR  = 6'b001000;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_mem_ready;
    logic       w_r_alu, w_shift_op, w_i_alu;
    logic [3:0] w_r_aluc, w_i_aluc;
    logic       w_jr, w_j, w_jal_op, w_lw, w_sw, w_beq, w_bne, w_to_exe, w_taken;
    logic       w_wpc, w_wir, w_wmem, w_wreg;

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_comb begin
        w_r_alu    = 1'b0;
        w_shift_op = 1'b0;
        w_r_aluc   = 4'b0000;
        if (bus.op == OP_RTYPE) begin
            w_r_alu = 1'b1;
            case (bus.func)
                F_ADD:   w_r_aluc = 4'b0000;
                F_SUB:   w_r_aluc = 4'b0100;
                F_AND:   w_r_aluc = 4'b0001;
                F_OR:    w_r_aluc = 4'b0101;
                F_XOR:   w_r_aluc = 4'b0010;
                F_SLL:   begin w_r_aluc = 4'b0011; w_shift_op = 1'b1; end
                F_SRL:   begin w_r_aluc = 4'b0111; w_shift_op = 1'b1; end
                F_SRA:   begin w_r_aluc = 4'b1111; w_shift_op = 1'b1; end
                default: w_r_alu = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_i_alu  = 1'b1;
        w_i_aluc = 4'b0000;
        case (bus.op)
            OP_ADDI: w_i_aluc = 4'b0000;
            OP_ANDI: w_i_aluc = 4'b0001;
            OP_ORI:  w_i_aluc = 4'b0101;
            OP_XORI: w_i_aluc = 4'b0010;
            OP_LUI:  w_i_aluc = 4'b0110;
            default: w_i_alu  = 1'b0;
        endcase
    end

    assign w_jr     = (bus.op == OP_RTYPE) && (bus.func == F_JR);
    assign w_j      = (bus.op == OP_J);
    assign w_jal_op = (bus.op == OP_JAL);
    assign w_lw     = (bus.op == OP_LW);
    assign w_sw     = (bus.op == OP_SW);
    assign w_beq    = (bus.op == OP_BEQ);
    assign w_bne    = (bus.op == OP_BNE);
    assign w_to_exe = w_r_alu | w_i_alu | w_lw | w_sw | w_beq | w_bne;
    assign w_taken  = (w_beq & bus.zero) | (w_bne & ~bus.zero);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IF;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = ST_IF;
        w_wpc        = 1'b0;
        w_wir        = 1'b0;
        w_wmem       = 1'b0;
        w_wreg       = 1'b0;
        bus.iord     = 1'b0;
        bus.regrt    = 1'b0;
        bus.m2reg    = 1'b0;
        bus.shift    = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.aluc     = 4'b0000;
        bus.pcsource = 2'b00;
        bus.jal      = 1'b0;
        bus.sext     = 1'b0;
        case (r_state)
            ST_IF: begin
                bus.alusrcb = 2'b01;
                if (w_mem_ready) begin
                    w_wir        = 1'b1;
                    w_wpc        = 1'b1;
                    w_state_next = ST_ID;
                end
            end
            ST_ID: begin
                // ALU meanwhile forms PC+offset<<2 so a branch finds its target ready.
                bus.alusrcb = 2'b11;
                bus.sext    = 1'b1;
                if (w_j) begin
                    w_wpc        = 1'b1;
                    bus.pcsource = 2'b11;
                end else if (w_jal_op) begin
                    w_wpc        = 1'b1;
                    w_wreg       = 1'b1;
                    bus.jal      = 1'b1;
                    bus.pcsource = 2'b11;
                end else if (w_jr) begin
                    w_wpc        = 1'b1;
                    bus.pcsource = 2'b10;
                end else if (w_to_exe) begin
                    w_state_next = ST_EXE;
                end
            end
            ST_EXE: begin
                bus.alusrca = 1'b1;
                if (w_r_alu) begin
                    bus.aluc     = w_r_aluc;
                    bus.shift    = w_shift_op;
                    w_state_next = ST_WB;
                end else if (w_i_alu) begin
                    bus.alusrcb  = 2'b10;
                    bus.aluc     = w_i_aluc;
                    bus.sext     = (bus.op == OP_ADDI);
                    w_state_next = ST_WB;
                end else if (w_lw | w_sw) begin
                    bus.alusrcb  = 2'b10;
                    bus.sext     = 1'b1;
                    w_state_next = ST_MEM;
                end else if (w_beq | w_bne) begin
                    bus.aluc = 4'b0100;
                    if (w_taken) begin
                        w_wpc        = 1'b1;
                        bus.pcsource = 2'b01;
                    end
                end
            end
            ST_MEM: begin
                bus.iord = 1'b1;
                if (w_lw) begin
                    w_state_next = w_mem_ready ? ST_WB : ST_MEM;
                end else if (w_sw) begin
                    w_wmem       = w_mem_ready;
                    w_state_next = w_mem_ready ? ST_IF : ST_MEM;
                end
            end
            ST_WB: begin
                w_wreg    = 1'b1;
                bus.regrt = ~w_r_alu;
                bus.m2reg = w_lw;
            end
            default: w_state_next = ST_IF;
        endcase
    end

    // State is already IF during reset, so strobes must be masked by resetn itself.
    assign bus.wpc   = w_wpc  & resetn;
    assign bus.wir   = w_wir  & resetn;
    assign bus.wmem  = w_wmem & resetn;
    assign bus.wreg  = w_wreg & resetn;
    assign bus.state = r_state;
endmodule

// File: tb/tb_mc_cu.sv
// Randomized bench for mc_cu: per-instruction expected cycle sequences from an instruction-level model.
module tb_mc_cu;
    logic clock = 1'b0;
    logic resetn;
    logic mr_drv;
    mc_cu_if bus();

    mc_cu dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

`ifdef MC_MEM_WAIT_EN
    assign bus.mem_ready = mr_drv;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
        logic [1:0] pcsource;
        logic jal, sext;
    } ctl_t;

    typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_JR,
                  K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
                  K_J, K_JAL, K_NOP} kind_t;

    ctl_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic ctl_t dut_ctl();
        ctl_t a;
        a.st = bus.state; a.wpc = bus.wpc; a.wir = bus.wir; a.wmem = bus.wmem;
        a.wreg = bus.wreg; a.iord = bus.iord; a.regrt = bus.regrt; a.m2reg = bus.m2reg;
        a.shift = bus.shift; a.alusrca = bus.alusrca; a.alusrcb = bus.alusrcb;
        a.aluc = bus.aluc; a.pcsource = bus.pcsource; a.jal = bus.jal; a.sext = bus.sext;
        return a;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Compare process: one expected control vector per cycle, sampled mid-cycle.
    always @(negedge clock) begin
        ctl_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_ctl();
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL ctl_vector state=%0d actual=%h required=%h", e.st, a, e);
        end
    end

    function automatic kind_t decode(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'd0: case (fn)
                6'h20: return K_ADD;  6'h22: return K_SUB;  6'h24: return K_AND;
                6'h25: return K_OR;   6'h26: return K_XOR;  6'h00: return K_SLL;
                6'h02: return K_SRL;  6'h03: return K_SRA;  6'h08: return K_JR;
                default: return K_NOP;
            endcase
            6'h08: return K_ADDI; 6'h0c: return K_ANDI; 6'h0d: return K_ORI;
            6'h0e: return K_XORI; 6'h0f: return K_LUI;  6'h23: return K_LW;
            6'h2b: return K_SW;   6'h04: return K_BEQ;  6'h05: return K_BNE;
            6'h02: return K_J;    6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(kind_t k);
        case (k)
            K_SUB, K_BEQ, K_BNE: return 4'b0100;
            K_AND, K_ANDI:       return 4'b0001;
            K_OR,  K_ORI:        return 4'b0101;
            K_XOR, K_XORI:       return 4'b0010;
            K_LUI:               return 4'b0110;
            K_SLL:               return 4'b0011;
            K_SRL:               return 4'b0111;
            K_SRA:               return 4'b1111;
            default:             return 4'b0000;
        endcase
    endfunction

    task automatic push(ctl_t e, logic mr);
        mr_drv = mr;
        exp_q.push_back(e);
        @(posedge clock); #1;
    endtask

    // Builds the whole expected cycle trace of one instruction and steps through it.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z,
                             int if_w, int mem_w, output int ncyc);
        kind_t k = decode(op, fn);
        bit is_r  = k inside {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA};
        bit is_i  = k inside {K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI};
        bit is_br = k inside {K_BEQ, K_BNE};
        ctl_t e;
        ncyc = 0;
        bus.op = op; bus.func = fn; bus.zero = z;
        for (int w = 0; w < if_w; w++) begin
            e = '0; e.st = 3'd0; e.alusrcb = 2'b01;
            push(e, 1'b0); ncyc++;
        end
        e = '0; e.st = 3'd0; e.wir = 1; e.wpc = 1; e.alusrcb = 2'b01;
        push(e, 1'b1); ncyc++;
        e = '0; e.st = 3'd1; e.alusrcb = 2'b11; e.sext = 1;
        if (k == K_J || k == K_JAL) begin e.wpc = 1; e.pcsource = 2'b11; end
        if (k == K_JAL) begin e.wreg = 1; e.jal = 1; end
        if (k == K_JR) begin e.wpc = 1; e.pcsource = 2'b10; end
        push(e, 1'b1); ncyc++;
        if (k inside {K_J, K_JAL, K_JR, K_NOP}) return;
        e = '0; e.st = 3'd2; e.alusrca = 1; e.aluc = alu_code(k);
        if (is_r) e.shift = (k inside {K_SLL, K_SRL, K_SRA});
        else if (is_i) begin e.alusrcb = 2'b10; e.sext = (k == K_ADDI); end
        else if (!is_br) begin e.alusrcb = 2'b10; e.sext = 1; end
        if (is_br && ((k == K_BEQ) ? z : !z)) begin e.wpc = 1; e.pcsource = 2'b01; end
        push(e, 1'b1); ncyc++;
        if (is_br) return;
        if (k == K_LW || k == K_SW) begin
            for (int w = 0; w < mem_w; w++) begin
                e = '0; e.st = 3'd3; e.iord = 1;
                push(e, 1'b0); ncyc++;
            end
            e = '0; e.st = 3'd3; e.iord = 1; e.wmem = (k == K_SW);
            push(e, 1'b1); ncyc++;
            if (k == K_SW) return;
        end
        e = '0; e.st = 3'd4; e.wreg = 1; e.regrt = !is_r; e.m2reg = (k == K_LW);
        push(e, 1'b1); ncyc++;
    endtask

    task automatic step_state(string name, logic [2:0] st);
        @(negedge clock);
        chk(name, 32'(bus.state), 32'(st));
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] tbl_op [20] = '{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
                                6'h08,6'h0c,6'h0d,6'h0e,6'h0f,6'h23,6'h2b,6'h04,6'h05,6'h02,6'h03};
    logic [5:0] tbl_fn [20] = '{6'h20,6'h22,6'h24,6'h25,6'h26,6'h00,6'h02,6'h03,6'h08,
                                6'h11,6'h22,6'h33,6'h00,6'h3f,6'h01,6'h02,6'h04,6'h05,6'h06,6'h07};

    initial begin
        int n, wi, wm, idx;
        logic [5:0] op, fn;
        resetn = 1'b0; mr_drv = 1'b1;
        bus.op = 6'b100011; bus.func = 6'h00; bus.zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("reset_state", 32'(bus.state), 32'd0);
            chk("reset_strobes", {28'd0, bus.wpc, bus.wir, bus.wmem, bus.wreg}, 32'd0);
        end
        @(posedge clock); #1 resetn = 1'b1;

        // Directed lw with literal expectations.
        @(negedge clock);
        chk("if_strobes", {29'd0, bus.wir, bus.wpc, bus.state == 3'd0}, 32'b111);
        chk("if_alusrcb", 32'(bus.alusrcb), 32'b01);
        @(posedge clock); #1;
        step_state("lw_id", 3'd1);
        @(negedge clock);
        chk("lw_exe", {24'd0, bus.state, bus.alusrca, bus.alusrcb, bus.sext, bus.wreg}, {24'd0, 3'd2, 1'b1, 2'b10, 1'b1, 1'b0});
        @(posedge clock); #1;
        @(negedge clock);
        chk("lw_mem", {28'd0, bus.state, bus.iord}, {28'd0, 3'd3, 1'b1});
        @(posedge clock); #1;
        @(negedge clock);
        chk("lw_wb", {26'd0, bus.state, bus.wreg, bus.m2reg, bus.regrt}, {26'd0, 3'd4, 3'b111});
        @(posedge clock); #1;

        // Directed instructions through the model, cycle counts pinned literally.
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, n); chk("add_cycles", 32'(n), 32'd4);
        run_instr(6'h23, 6'h00, 1'b0, 0, 0, n); chk("lw_cycles",  32'(n), 32'd5);
        run_instr(6'h2b, 6'h00, 1'b0, 0, 0, n); chk("sw_cycles",  32'(n), 32'd4);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, n); chk("beq_t_cycles", 32'(n), 32'd3);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, n);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, n);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0, n); chk("bne_cycles", 32'(n), 32'd3);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0, n); chk("jal_cycles", 32'(n), 32'd2);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0, n); chk("jr_cycles",  32'(n), 32'd2);
        run_instr(6'h3f, 6'h3f, 1'b0, 0, 0, n); chk("nop_cycles", 32'(n), 32'd2);
`ifdef MC_MEM_WAIT_EN
        run_instr(6'h3f, 6'h00, 1'b0, 3, 0, n); chk("ifwait_cycles", 32'(n), 32'd5);
        run_instr(6'h2b, 6'h00, 1'b0, 0, 2, n); chk("swwait_cycles", 32'(n), 32'd6);
`endif

        // Randomized instruction stream.
        for (int t = 0; t < 300; t++) begin
            idx = $urandom_range(0, 23);
            if (idx < 20) begin op = tbl_op[idx]; fn = (op == 6'h00) ? tbl_fn[idx] : 6'($urandom); end
            else begin op = 6'($urandom); fn = 6'($urandom); end
`ifdef MC_MEM_WAIT_EN
            wi = $urandom_range(0, 2); wm = $urandom_range(0, 2);
`else
            wi = 0; wm = 0;
`endif
            run_instr(op, fn, 1'($urandom), wi, wm, n);
        end

        // Async reset pulse while lw sits in MEM.
        bus.op = 6'h23; bus.func = 6'h00; mr_drv = 1'b1;
        step_state("ar_if", 3'd0);
        step_state("ar_id", 3'd1);
        step_state("ar_exe", 3'd2);
        chk("ar_mem", 32'(bus.state), 32'd3);
        #2 resetn = 1'b0;
        #1;
        chk("ar_state", 32'(bus.state), 32'd0);
        chk("ar_strobes", {28'd0, bus.wpc, bus.wir, bus.wmem, bus.wreg}, 32'd0);
        @(posedge clock); #1 resetn = 1'b1;
        run_instr(6'h00, 6'h03, 1'b0, 0, 0, n); chk("sra_cycles", 32'(n), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
